// File: rtl/flexpipe_pkg.sv
// flexpipe_pkg: shared layer configuration, execution states and error bit indices
package flexpipe_pkg;
  localparam int EPOCH_WIDTH = 8;
  localparam int CFG_CNT_W = 32;
  typedef struct packed {
    logic                   valid;
    logic [EPOCH_WIDTH-1:0] epoch;
    logic [CFG_CNT_W-1:0]   pointer_walks;
    logic [CFG_CNT_W-1:0]   compute_cycles;
  } layer_config_t;
  typedef enum logic [2:0] {IDLE, ARMED, ISSUE, COMPUTE, DRAIN} exec_state_e;
  localparam int ERR_BAD_START = 0;
  localparam int ERR_RSP_UNDERFLOW = 1;
endpackage

// File: rtl/layer_exec_ctrl_outstanding_tracker.sv
// outstanding_tracker: up/down count of walk requests in flight with limit and underflow flag
//   inc/dec      issue and response events (same-cycle pair nets to zero)
//   count        requests in flight
//   at_max       count has reached MAX_OUTSTANDING
//   is_zero      nothing in flight
//   underflow    response seen with nothing in flight and no issue (dropped)
module outstanding_tracker #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         is_zero,
  output logic         underflow
);
  assign at_max = count == W'(MAX_OUTSTANDING);
  assign is_zero = count == '0;
  assign underflow = dec && !inc && is_zero;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !dec) count <= count + 1'b1;
    else if (dec && !inc && !is_zero) count <= count - 1'b1;
endmodule

// File: rtl/layer_exec_ctrl.sv
// layer_exec_ctrl: runs one layer (walk issue, compute, drain) and grants config flips only between layers
//   active_config/layer_start_pulse/current_epoch  layer launch from config_manager
//   request_flip/flip_ack/core_safe_to_flip/no_outstanding_active  flip handshake
//   walk_req_*/walk_rsp_valid  pointer-walk request channel and completions
//   layer_busy/layer_done/err_sticky  status (err bit0 bad start, bit1 response underflow)
module layer_exec_ctrl
  import flexpipe_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  layer_config_t          active_config,
  input  logic                   layer_start_pulse,
  input  logic [EPOCH_WIDTH-1:0] current_epoch,
  input  logic                   request_flip,
  output logic                   flip_ack,
  output logic                   core_safe_to_flip,
  output logic                   no_outstanding_active,
  output logic                   walk_req_valid,
  input  logic                   walk_req_ready,
  output logic [CNT_W-1:0]       walk_req_idx,
  output logic [EPOCH_WIDTH-1:0] walk_req_epoch,
  input  logic                   walk_rsp_valid,
  output logic                   layer_busy,
  output logic                   layer_done,
  output logic [1:0]             err_sticky
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  exec_state_e state;
  logic [CNT_W-1:0] issued, cnt, cfg_pw;
  logic [EPOCH_WIDTH-1:0] cfg_epoch;
  logic [OW-1:0] outstanding;
  logic ack_block, at_max, is_zero, underflow, issue_fire, start_ok, can_start;
  outstanding_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .W(OW)) u_tracker (
    .clk(clk),
    .rst_n(rst_n),
    .inc(issue_fire),
    .dec(walk_rsp_valid),
    .count(outstanding),
    .at_max(at_max),
    .is_zero(is_zero),
    .underflow(underflow)
  );
  assign core_safe_to_flip = state == IDLE;
  assign layer_busy = state != IDLE;
  assign no_outstanding_active = is_zero;
  assign walk_req_valid = state == ISSUE && issued < cfg_pw && !at_max;
  assign walk_req_idx = issued;
  assign walk_req_epoch = cfg_epoch;
  assign issue_fire = walk_req_valid && walk_req_ready;
  assign start_ok = active_config.valid && active_config.epoch == current_epoch;
  assign can_start = state == IDLE || state == ARMED;
  // flip_ack is raised while still in IDLE; ARMED follows one cycle later so the
  // core_safe_to_flip drop trails the grant. ack_block keeps a held request to one ack.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      issued <= '0;
      cnt <= '0;
      cfg_pw <= '0;
      cfg_epoch <= '0;
      ack_block <= 1'b0;
      flip_ack <= 1'b0;
      layer_done <= 1'b0;
      err_sticky <= '0;
    end else begin
      flip_ack <= 1'b0;
      layer_done <= 1'b0;
      if (underflow) err_sticky[ERR_RSP_UNDERFLOW] <= 1'b1;
      if (!request_flip) ack_block <= 1'b0;
      if (layer_start_pulse && can_start) begin
        ack_block <= 1'b0;
        cfg_pw <= CNT_W'(active_config.pointer_walks);
        cfg_epoch <= active_config.epoch;
        cnt <= CNT_W'(active_config.compute_cycles);
        issued <= '0;
        if (!start_ok) err_sticky[ERR_BAD_START] <= 1'b1;
        state <= !start_ok ? IDLE : active_config.pointer_walks == '0 ? COMPUTE : ISSUE;
      end else begin
        if (layer_start_pulse) err_sticky[ERR_BAD_START] <= 1'b1;
        case (state)
          IDLE:
            if (flip_ack) state <= ARMED;
            else if (request_flip && outstanding == '0 && !ack_block) begin
              flip_ack <= 1'b1;
              ack_block <= 1'b1;
            end
          ISSUE:
            if (issue_fire) begin
              issued <= issued + 1'b1;
              if (issued + 1'b1 == cfg_pw) state <= COMPUTE;
            end
          COMPUTE:
            if (cnt == '0) state <= DRAIN;
            else cnt <= cnt - 1'b1;
          DRAIN:
            if (outstanding == '0) begin
              layer_done <= 1'b1;
              state <= IDLE;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: doc/layer_exec_ctrl.md
Name: layer_exec_ctrl

Overview:
Core-side execution controller directly downstream of config_manager. It consumes active_config and layer_start_pulse, issues the layer's pointer-walk requests with back-pressure and an outstanding-request limit, then counts compute cycles. It drives the flip handshake back to config_manager through core_safe_to_flip, no_outstanding_active and flip_ack, so that a shadow-to-active flip only occurs between layers with nothing in flight.

Parameters:
MAX_OUTSTANDING, 8, maximum walk requests in flight (1..255)
CNT_W, 32, width of the walk and compute counters; matches the layer_config_t count fields

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
active_config  in  layer_config_t  config from config_manager
layer_start_pulse  in  1  one-cycle start of a new layer
current_epoch  in  EPOCH_WIDTH  epoch from config_manager
request_flip  in  1  flip request (level)
flip_ack  out  1  one-cycle flip grant
core_safe_to_flip  out  1  core idle between layers
no_outstanding_active  out  1  outstanding count == 0
walk_req_valid  out  1  walk request valid
walk_req_ready  in  1  walk request accepted
walk_req_idx  out  CNT_W  walk index 0..pointer_walks-1
walk_req_epoch  out  EPOCH_WIDTH  epoch tag of the request
walk_rsp_valid  in  1  one walk response completes
layer_busy  out  1  state is not IDLE
layer_done  out  1  one-cycle pulse at layer end
err_sticky  out  2  bit0 bad start, bit1 response underflow

Behaviour:
- Reset is asynchronous, active-low; it may be applied mid-operation and aborts any layer in progress.
  - Every output resets to 0, except core_safe_to_flip and no_outstanding_active, which reset to 1.
  - State resets to IDLE; all counters reset to 0.
- States: IDLE, ARMED, ISSUE, COMPUTE, DRAIN.
  - core_safe_to_flip = 1 only in IDLE.
  - no_outstanding_active = 1 when outstanding == 0 (registered count).
- IDLE:
  - If request_flip && outstanding == 0 && !ack_block: flip_ack = 1 on the next cycle, then go to ARMED.
  - ack_block sets when flip_ack fires. It clears when request_flip is seen low or when the layer starts. This guarantees exactly one ack per request.
  - A layer_start_pulse in IDLE without a preceding ack is handled as a start (same checks as ARMED).
- ARMED: wait for layer_start_pulse.
  - Latch active_config into a local copy.
  - If !valid or epoch != current_epoch: set err_sticky[0] and return to IDLE.
  - Otherwise go to ISSUE. If pointer_walks == 0, go straight to COMPUTE instead.
- ISSUE:
  - walk_req_valid = (issued < pointer_walks) && outstanding < MAX_OUTSTANDING.
  - walk_req_idx = issued; walk_req_epoch = latched epoch.
  - Both are held stable while walk_req_valid && !walk_req_ready.
  - On handshake: issued++ and outstanding++.
  - After the last handshake, go to COMPUTE.
- COMPUTE:
  - A down-counter loads compute_cycles and decrements once per cycle.
  - Leave COMPUTE when the count is 0 (compute_cycles == 0 means 0 cycles spent), going to DRAIN.
- DRAIN: wait until outstanding == 0, then pulse layer_done and go to IDLE.
- Outstanding counter:
  - Issue and response in the same cycle: net 0 change.
  - walk_rsp_valid with outstanding == 0 and no issue that cycle: ignore it and set err_sticky[1].
  - Responses are accepted in every state.
- layer_start_pulse in ISSUE, COMPUTE or DRAIN is ignored and sets err_sticky[0].
- request_flip during a layer gets no ack until the controller returns to IDLE with outstanding == 0.
- Counter widths: issued and compute counters are CNT_W bits; outstanding is clog2(MAX_OUTSTANDING+1) bits. No wrap is possible because of the limits.

Decomposition:
- flexpipe_pkg:
  - layer_config_t (existing);
  - exec_state_e enum;
  - ERR_BAD_START / ERR_RSP_UNDERFLOW bit indices.
- One sub-module, outstanding_tracker:
  - up/down counter with a MAX_OUTSTANDING limit and an underflow flag;
  - outputs count, at_max, is_zero.

Test Plan:
- Flip handshake: request_flip held high for 3 cycles in IDLE, outstanding 0 -> flip_ack high for exactly 1 cycle; core_safe_to_flip falls the cycle after the ack; no second ack.
- Normal layer: start with pointer_walks = 4, compute_cycles = 5, valid = 1, epoch matching, walk_req_ready = 1, response 2 cycles after each request -> idx 0..3 issued on consecutive cycles; layer_done after COMPUTE + drain; no_outstanding_active = 1 at done.
- Back-pressure and limit: MAX_OUTSTANDING = 2, pointer_walks = 5, no responses -> exactly 2 requests issued and valid drops. One response -> exactly one more request. Idx is held stable while walk_req_ready = 0.
- Bad start: start with valid = 0, or epoch = current_epoch − 1 -> err_sticky = 2'b01; state returns to IDLE; no walk requests issued.
- Edge cases: pointer_walks = 0 and compute_cycles = 0 -> layer_done within 3 cycles of the start. A stray walk_rsp_valid in IDLE -> err_sticky[1] = 1 and outstanding stays 0.
- Reset mid-ISSUE with 3 outstanding -> all counters 0; core_safe_to_flip = 1, no_outstanding_active = 1; walk_req_valid = 0 immediately (asynchronous).
